// File: rtl/my_tdm_pkg.sv
// Shared definitions for the TDM link (my_tdm_mux transmit / my_tdm_dmux receive).
package my_tdm_pkg;

    localparam int unsigned DefChannels = 4;
    localparam int unsigned DefWidth    = 8;

    typedef enum logic {
        IDLE,
        RECV
    } tdm_state_t;

endpackage

// File: rtl/my_tdm_dmux_if.sv
// Serial input and parallel frame output bundle of the TDM receiver.
interface my_tdm_dmux_if
    import my_tdm_pkg::*;
#(
    parameter int unsigned CHANNELS = DefChannels,
    parameter int unsigned WIDTH    = DefWidth
);

    logic                      ser_in;
    logic                      ser_valid;
    logic                      ser_sof;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic                      out_valid;
    logic                      out_err;

    modport master (
        output ser_in, ser_valid, ser_sof,
        input  out_data, out_valid, out_err
    );

    modport slave (
        input  ser_in, ser_valid, ser_sof,
        output out_data, out_valid, out_err
    );

endinterface

// File: rtl/my_sipo.sv
// Serial-in/parallel-out word register, LSB first: new bits enter at the MSB and move down.
module my_sipo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             din_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] data_q, data_d;

    // clr_i with shift_i loads din_i as the first bit of a fresh word.
    always_comb begin
        data_d = data_q;
        if (clr_i && shift_i) begin
            data_d = {din_i, {(WIDTH-1){1'b0}}};
        end else if (clr_i) begin
            data_d = '0;
        end else if (shift_i) begin
            data_d = {din_i, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // Value the register holds after this edge: the complete word on a slot's last bit.
    assign word_o = data_d;

endmodule

// File: rtl/my_tdm_dmux.sv
// TDM receiver: reassembles a bit-serial frame of CHANNELS words and publishes it atomically.
module my_tdm_dmux
    import my_tdm_pkg::*;
#(
    parameter int unsigned CHANNELS = DefChannels,
    parameter int unsigned WIDTH    = DefWidth
) (
    input  logic          clk,
    input  logic          reset,
    my_tdm_dmux_if.slave  bus
);

    localparam int unsigned BitW  = $clog2(WIDTH);
    localparam int unsigned SlotW = $clog2(CHANNELS);

    tdm_state_t                state_q, state_d;
    logic [BitW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [SlotW-1:0]          slot_cnt_q, slot_cnt_d;
    // The final slot goes straight to the output, so only CHANNELS-1 words need shadowing.
    logic [WIDTH-1:0]          shadow_q [CHANNELS-1];
    logic [WIDTH-1:0]          shadow_d [CHANNELS-1];
    logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_err_q, out_err_d;

    logic                      sipo_clr, sipo_shift;
    logic [WIDTH-1:0]          word_full;
    logic [CHANNELS*WIDTH-1:0] frame;
    logic                      last_bit, last_slot;

    my_sipo #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (sipo_clr),
        .shift_i (sipo_shift),
        .din_i   (bus.ser_in),
        .word_o  (word_full)
    );

    assign last_bit  = (bit_cnt_q == BitW'(WIDTH - 1));
    assign last_slot = (slot_cnt_q == SlotW'(CHANNELS - 1));

    always_comb begin
        frame = '0;
        for (int c = 0; c < int'(CHANNELS) - 1; c++) begin
            frame[c*WIDTH +: WIDTH] = shadow_q[c];
        end
        frame[(CHANNELS-1)*WIDTH +: WIDTH] = word_full;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        slot_cnt_d  = slot_cnt_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;
        sipo_clr    = 1'b0;
        sipo_shift  = 1'b0;

        if (bus.ser_valid) begin
            if (bus.ser_sof) begin
                // A sof beat always starts slot 0; inside a frame it also aborts the old one.
                out_err_d  = (state_q == RECV);
                state_d    = RECV;
                bit_cnt_d  = BitW'(1);
                slot_cnt_d = '0;
                sipo_clr   = 1'b1;
                sipo_shift = 1'b1;
            end else if (state_q == RECV) begin
                sipo_shift = 1'b1;
                if (!last_bit) begin
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                end else begin
                    bit_cnt_d = '0;
                    if (last_slot) begin
                        out_data_d  = frame;
                        out_valid_d = 1'b1;
                        slot_cnt_d  = '0;
                        state_d     = IDLE;
                    end else begin
                        shadow_d[slot_cnt_q] = word_full;
                        slot_cnt_d           = slot_cnt_q + SlotW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            slot_cnt_q  <= '0;
            shadow_q    <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            slot_cnt_q  <= slot_cnt_d;
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_err   = out_err_q;

endmodule
